// File: rtl/serdes_pkg.sv
// Shared definitions for the 10-bit serial link: word width, comma code,
// aligner state encoding and a saturating counter helper.
package serdes_pkg;

   localparam int unsigned WORD_W  = 10;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned PHASE_W = 4;

   localparam logic [WORD_W-1:0]  K28_5      = 10'b0011111010;
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } align_state_e;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : CNT_W'(v + 1'b1);
   endfunction

endpackage

// File: rtl/word_align_fsm.sv
// Word-boundary aligner: hunts for a comma, confirms it over repeated aligned
// commas, and drops lock after too many misaligned ones.
module word_align_fsm
   import serdes_pkg::*;
#(
   parameter int unsigned LOCK_COUNT   = 3,
   parameter int unsigned UNLOCK_COUNT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic comma_now,
   input  logic phase_zero,
   output logic realign,
   output logic capture,
   output logic locked
);

   localparam logic [CNT_W-1:0] LOCK_CNT   = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] UNLOCK_CNT = CNT_W'(UNLOCK_COUNT);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   align_state_e     state, state_nxt;
   logic [CNT_W-1:0] comma_cnt, comma_cnt_nxt;
   logic [CNT_W-1:0] err_cnt, err_cnt_nxt;
   logic [CNT_W-1:0] comma_inc, err_inc;

   assign comma_inc = sat_inc(comma_cnt);
   assign err_inc   = sat_inc(err_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         comma_cnt <= '0;
         err_cnt   <= '0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nxt;
         comma_cnt <= comma_cnt_nxt;
         err_cnt   <= err_cnt_nxt;
         locked    <= (state_nxt == LOCKED);
      end
   end

   always_comb begin
      state_nxt     = state;
      comma_cnt_nxt = comma_cnt;
      err_cnt_nxt   = err_cnt;
      realign       = 1'b0;
      capture       = 1'b0;

      case (state)
         HUNT: begin
            if (comma_now) begin
               realign       = 1'b1;
               comma_cnt_nxt = CNT_ONE;
               if (LOCK_COUNT == 1) begin
                  state_nxt   = LOCKED;
                  err_cnt_nxt = '0;
               end else begin
                  state_nxt = SYNC;
               end
            end
         end

         SYNC: begin
            if (comma_now && phase_zero) begin
               comma_cnt_nxt = comma_inc;
               if (comma_inc >= LOCK_CNT) begin
                  state_nxt   = LOCKED;
                  err_cnt_nxt = '0;
               end
            end else if (comma_now) begin
               realign       = 1'b1;
               comma_cnt_nxt = CNT_ONE;
            end
         end

         LOCKED: begin
            capture = phase_zero;
            if (comma_now && phase_zero) begin
               err_cnt_nxt = '0;
            end else if (comma_now) begin
               // Misaligned comma; no realign on the cycle lock is dropped.
               if (err_inc >= UNLOCK_CNT) begin
                  state_nxt     = HUNT;
                  comma_cnt_nxt = '0;
                  err_cnt_nxt   = '0;
               end else begin
                  err_cnt_nxt = err_inc;
               end
            end
         end

         default: state_nxt = HUNT;
      endcase
   end

endmodule

// File: rtl/serial_to_para.sv
// Receive deserializer: shifts the MSB-first serial stream in, aligns on a
// comma and presents each aligned word with a one-cycle valid strobe.
module serial_to_para
   import serdes_pkg::*;
#(
   parameter logic [WORD_W-1:0] COMMA        = K28_5,
   parameter int unsigned       LOCK_COUNT   = 3,
   parameter int unsigned       UNLOCK_COUNT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              serial_in,
   output logic [WORD_W-1:0] para_out,
   output logic              word_valid,
   output logic              comma_flag,
   output logic              locked
);

   logic [WORD_W-1:0]  sr;
   logic [PHASE_W-1:0] phase;
   logic               comma_now;
   logic               phase_zero;
   logic               realign;
   logic               capture;

   assign comma_now  = (sr == COMMA);
   assign phase_zero = (phase == '0);

   word_align_fsm #(
      .LOCK_COUNT   (LOCK_COUNT),
      .UNLOCK_COUNT (UNLOCK_COUNT)
   ) u_align (
      .clk        (clk),
      .rst_n      (rst_n),
      .comma_now  (comma_now),
      .phase_zero (phase_zero),
      .realign    (realign),
      .capture    (capture),
      .locked     (locked)
   );

   // A realign fires the cycle after the comma completes, so phase restarts at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr         <= '0;
         phase      <= '0;
         para_out   <= '0;
         word_valid <= 1'b0;
         comma_flag <= 1'b0;
      end else begin
         sr         <= {sr[WORD_W-2:0], serial_in};
         word_valid <= capture;
         comma_flag <= capture & comma_now;
         if (capture) begin
            para_out <= sr;
         end
         if (realign) begin
            phase <= PHASE_W'(1);
         end else if (phase == PHASE_LAST) begin
            phase <= '0;
         end else begin
            phase <= PHASE_W'(phase + 1'b1);
         end
      end
   end

endmodule

// File: doc/serial_to_para.md
# serial_to_para

Receive-side deserializer for the 10-bit serial link driven by `para_to_serial`, which sends MSB first, one bit per clock, and uses no framing strobe. This block shifts the serial stream in and finds word boundaries by detecting a K28.5 comma. It declares lock after repeated aligned commas and then presents each aligned 10-bit word with a one-cycle valid strobe. It sits in the color-filter test path between the serial link and the parallel checker/decoder.

## Interface
Parameters:
- `COMMA`, default 10'b0011111010: alignment pattern (K28.5, RD−), compared MSB-first.
- `LOCK_COUNT`, default 3: aligned commas required to enter LOCKED (range 1–15).
- `UNLOCK_COUNT`, default 4: misaligned commas, counted while LOCKED, that force HUNT (range 1–15).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `serial_in`  in  1  serial bit sampled every rising edge; MSB of each word arrives first.
- `para_out`  out  10  last aligned word, registered; holds its value between strobes.
- `word_valid`  out  1  one-cycle pulse when `para_out` is updated (LOCKED only).
- `comma_flag`  out  1  qualifies `word_valid`: the presented word equals `COMMA`.
- `locked`  out  1  high while the FSM is in LOCKED.

## Operation
- Shift register `sr[9:0]` updates every cycle: `sr <= {sr[8:0], serial_in}`.
- `comma_now = (sr == COMMA)`. This is combinational on the current `sr`.
- Phase counter `phase`, 0–9. `phase==0` means `sr` currently holds an aligned word. Default update: 9 wraps to 0, otherwise increment.
- Realign action: `phase <= 1`.
- FSM states:
  - HUNT:
    - On `comma_now`: realign, set `comma_cnt <= 1`, go to SYNC. If `LOCK_COUNT==1`, go directly to LOCKED.
    - Otherwise `phase` runs free.
  - SYNC:
    - `comma_now` at `phase==0`: `comma_cnt++`. Reaching `LOCK_COUNT` → LOCKED, with `err_cnt <= 0`.
    - `comma_now` at `phase!=0`: realign, set `comma_cnt <= 1`, stay in SYNC.
    - Non-comma words at `phase==0` are ignored and not output.
  - LOCKED:
    - At `phase==0`: `para_out <= sr`, `word_valid <= 1`, `comma_flag <= comma_now`. An aligned comma also clears `err_cnt`.
    - `comma_now` at `phase!=0`: `err_cnt++`. Reaching `UNLOCK_COUNT` → HUNT, clear both counters, no realign on that cycle.
- `comma_cnt` and `err_cnt` are 4-bit and saturate; they cannot wrap.
- `locked` is driven from the state register. It is high from the cycle after the transition into LOCKED and low from the cycle after the transition to HUNT.
- A shifted comma sequence can also match `comma_now` (e.g. comma-in-data). Outside LOCKED it is handled like any other comma; in LOCKED it counts as a misalignment.

## Timing
- Reset values (all asynchronous on `rst_n` low): `sr=0`, `phase=0`, state HUNT, counters 0, `para_out=0`, `word_valid=0`, `comma_flag=0`, `locked=0`.
- With `sr=0` after reset, zeros never match `COMMA`, so no spurious lock. This covers the transmitter's reset output of 10 zero bits.
- Latency: the last bit of a word is sampled on edge E, `sr` holds the word after E, and `para_out`/`word_valid` update on E+1. That is 2 edges from the last-bit sample to visible output.
- In steady LOCKED operation, `word_valid` pulses exactly once every 10 cycles, never on consecutive cycles.
- Lock time from the first comma's last bit, with back-to-back commas: `(LOCK_COUNT−1)*10` cycles to the transition, plus 1 cycle for `locked`.
- Simultaneous events: when an aligned-word output and the LOCKED→HUNT transition fall in the same cycle, they cannot coincide, because a misaligned comma implies `phase!=0`.
- Reset mid-word: outputs clear immediately and asynchronously. On release, the block restarts in HUNT and requires full re-lock.

## Structure
- Shared package `serdes_pkg`:
  - `WORD_W=10`
  - `K28_5=10'b0011111010`
  - state enum `{HUNT, SYNC, LOCKED}` (2-bit)
  - `CNT_W=4`
- One natural sub-module, `word_align_fsm`:
  - inputs `comma_now`, `phase_zero`
  - outputs `realign`, `capture`, `locked`
  - owns the state register and both counters
- The top level holds `sr`, `phase`, the comparator and the output registers. Expected size is 150–250 lines total.

## Test plan
- Reset, 10 zero bits, then 3 commas with a 3-bit leading offset → `locked` rises 21 cycles after the last bit of the first comma; `word_valid` never pulses before lock.
- Locked stream: `COMMA`, 10'h2AA, 10'h0F0, 10'h155 → `para_out` shows each value in order, one `word_valid` every 10 cycles, `comma_flag` high only on `COMMA`.
- Slip in LOCKED (one extra bit inserted), then repeated commas → 4 misaligned commas drop `locked`; realign occurs and `locked` returns after 3 further aligned commas.
- In LOCKED: one misaligned comma, then one aligned comma, then 3 more misaligned → `locked` stays high (`err_cnt` was cleared).
- In SYNC after 2 aligned commas, a comma arrives at a 4-bit offset → `comma_cnt` restarts at 1, and lock requires 2 more commas at the new alignment.
- `rst_n` pulsed low mid-word while LOCKED → all outputs 0 within the low pulse, with no clock edge needed; after release, full re-lock is required.
